// File: rtl/hazard_ctrl.sv
// hazard_ctrl: tracks in-flight destinations to pick forwarding sources, detect load-use stalls
// and generate branch flush bubbles, with saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int AW        = 5,
    parameter int DEPTH     = 3,
    parameter int LOAD_LAT  = 1,
    parameter int FLUSH_CYC = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    input  logic          id_rs1_used,
    input  logic          id_rs2_used,
    input  logic [AW-1:0] id_rd,
    input  logic          id_wen,
    input  logic          id_is_load,
    input  logic          br_resolve,
    input  logic          br_taken,
    output logic [2:0]    fwd_a,
    output logic [2:0]    fwd_b,
    output logic          stall,
    output logic          flush,
    output logic [15:0]   perf_stall,
    output logic [15:0]   perf_flush
);
    logic [DEPTH:1] v, w, ld;
    logic [AW-1:0]  rd [DEPTH:1];
    logic [3:0]     fc;
    logic [2:0]     sel_a, sel_b;
    logic           haz_a, haz_b, take;

    // Scan oldest to youngest so the youngest match wins; a too-young load hides itself and raises a hazard.
    always_comb begin
        take  = br_resolve && br_taken;
        sel_a = '0;
        sel_b = '0;
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (v[k] && w[k] && rd[k] != '0 && rd[k] == id_rs1 && id_rs1_used) begin
                haz_a = ld[k] && (k <= LOAD_LAT);
                sel_a = haz_a ? 3'd0 : 3'(k);
            end
            if (v[k] && w[k] && rd[k] != '0 && rd[k] == id_rs2 && id_rs2_used) begin
                haz_b = ld[k] && (k <= LOAD_LAT);
                sel_b = haz_b ? 3'd0 : 3'(k);
            end
        end
        flush = !rst && (take || fc != '0);
        stall = !rst && id_valid && !flush && (haz_a || haz_b);
        fwd_a = (rst || stall) ? 3'd0 : sel_a;
        fwd_b = (rst || stall) ? 3'd0 : sel_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v          <= '0;
            w          <= '0;
            ld         <= '0;
            for (int k = 1; k <= DEPTH; k++) rd[k] <= '0;
            fc         <= '0;
            perf_stall <= '0;
            perf_flush <= '0;
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                v[k]  <= v[k-1];
                w[k]  <= w[k-1];
                ld[k] <= ld[k-1];
                rd[k] <= rd[k-1];
            end
            v[1]       <= id_valid && !stall && !flush;
            w[1]       <= id_wen;
            ld[1]      <= id_is_load;
            rd[1]      <= id_rd;
            fc         <= take ? 4'(FLUSH_CYC - 1) : (fc != '0 ? fc - 4'd1 : fc);
            perf_stall <= perf_stall + 16'(stall && perf_stall != 16'hFFFF);
            perf_flush <= perf_flush + 16'(take && perf_flush != 16'hFFFF);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed per-cycle vectors; the driver queues hand-computed expectations
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_wen = 1'b0, id_is_load = 1'b0, br_resolve = 1'b0, br_taken = 1'b0;
    logic [2:0]  fwd_a, fwd_b;
    logic        stall, flush;
    logic [15:0] perf_stall, perf_flush;

    typedef struct {
        string       nm;
        logic [2:0]  fa, fb;
        logic        st, fl;
        logic [15:0] ps, pf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_wen(id_wen),
        .id_is_load(id_is_load), .br_resolve(br_resolve), .br_taken(br_taken),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .flush(flush),
        .perf_stall(perf_stall), .perf_flush(perf_flush)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string f, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, f, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.nm, "fwd_a", 16'(fwd_a), 16'(e.fa));
            cmp(e.nm, "fwd_b", 16'(fwd_b), 16'(e.fb));
            cmp(e.nm, "stall", 16'(stall), 16'(e.st));
            cmp(e.nm, "flush", 16'(flush), 16'(e.fl));
            cmp(e.nm, "perf_stall", perf_stall, e.ps);
            cmp(e.nm, "perf_flush", perf_flush, e.pf);
        end
    end

    // r: reset level applied this cycle; then decode fields, branch, and expected outputs.
    task automatic step(input string nm, input logic r, input logic iv,
                        input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                        input logic [4:0] rd, input logic wn, input logic lo,
                        input logic br, input logic bt,
                        input logic [2:0] fa, input logic [2:0] fb, input logic st, input logic fl,
                        input logic [15:0] ps, input logic [15:0] pf);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_valid = iv; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
        id_rd = rd; id_wen = wn; id_is_load = lo; br_resolve = br; br_taken = bt;
        e.nm = nm; e.fa = fa; e.fb = fb; e.st = st; e.fl = fl; e.ps = ps; e.pf = pf;
        q.push_back(e);
    endtask

    initial begin
        //    name          r  iv r1 u1 r2 u2 rd wn lo br bt   fa fb st fl ps pf
        step("reset",       1, 1, 5, 1, 5, 1, 5, 1, 1, 1, 1,   0, 0, 0, 0, 0, 0);
        step("wr_x5",       0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step("fwd_k1",      0, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        step("fwd_k2",      0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0);
        step("fwd_k3",      0, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0,   3, 2, 0, 0, 0, 0);
        step("fwd_aged",    0, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0,   0, 3, 0, 0, 0, 0);
        step("wr_x0",       0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step("rd_x0",       0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step("wr_x9",       0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step("unused_src",  0, 1, 9, 0, 9, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);
        step("wr_x3_a",     0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step("wr_x3_b",     0, 1, 3, 1, 0, 0, 3, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        step("youngest",    0, 1, 3, 1, 9, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        step("load_x7",     0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("load_use",    0, 1, 3, 1, 7, 1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0);
        step("stall_rel",   0, 1, 3, 1, 7, 1, 0, 0, 0, 0, 0,   0, 2, 0, 0, 1, 0);
        step("br_t",        0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 1, 0);
        step("br_t1",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 1);
        step("br_t2",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1);
        step("br_not_tkn",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 1, 1);
        step("load_x7_b",   0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0,   0, 0, 0, 0, 1, 1);
        step("flush_ovr",   0, 1, 7, 1, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 1, 1);
        step("br_extend",   0, 1, 7, 1, 0, 0, 0, 0, 0, 1, 1,   2, 0, 0, 1, 1, 2);
        step("ext_tail",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1, 3);
        step("ext_done",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 3);
        step("br_pre_rst",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 1, 1, 3);
        step("rst_flush",   1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0);
        step("post_rst",    0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("stall_b",     0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0);
        step("rst_stall",   1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step("no_stale",    0, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step("load_x7_c",   0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step("no_id_valid", 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        step("idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter AW, default 5, register-address width.
REQ-002 Parameter DEPTH, default 3, legal 1..7, number of in-flight destination stages tracked beyond decode.
REQ-003 Parameter LOAD_LAT, default 1, legal 0..DEPTH-1, stages a load result is unavailable for forwarding.
REQ-004 Parameter FLUSH_CYC, default 2, legal 1..15, bubble cycles per taken branch.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 id_valid  in  1  decode stage holds a valid instruction.
REQ-008 id_rs1, id_rs2  in  AW  source register indices.
REQ-009 id_rs1_used, id_rs2_used  in  1  the instruction reads that source.
REQ-010 id_rd  in  AW  destination register index.
REQ-011 id_wen  in  1  the instruction writes id_rd.
REQ-012 id_is_load  in  1  the instruction is a load.
REQ-013 br_resolve  in  1  a branch or jump is resolved this cycle.
REQ-014 br_taken  in  1  the resolved branch or jump is taken; ignored when br_resolve=0.
REQ-015 fwd_a, fwd_b  out  3  forward source selects: 0 = register file, k = tracking stage k (1 = youngest).
REQ-016 stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.
REQ-017 flush  out  1  invalidate IF/ID and ID/EX contents.
REQ-018 perf_stall, perf_flush  out  16  saturating event counters.

Function
REQ-019 The block SHALL keep a DEPTH-entry tracking shift register; each entry holds {valid, rd, wen, is_load}.
REQ-020 Each cycle, entry k SHALL load entry k-1, and entry DEPTH SHALL be discarded.
REQ-021 Entry 1 SHALL load the decode fields when id_valid=1, stall=0 and flush=0; otherwise it SHALL load valid=0.
REQ-022 An entry "matches" a source when valid=1, wen=1, rd!=0, rd equals that source index, and the corresponding *_used=1.
REQ-023 fwd_a (fwd_b) SHALL be combinational and equal the smallest matching k for rs1 (rs2), or 0 when no entry matches.
REQ-024 A matching entry with is_load=1 and k<=LOAD_LAT SHALL NOT be selected; stall SHALL be 1 instead.
REQ-025 stall SHALL be combinational, and 1 only when id_valid=1, flush=0 and REQ-024 applies to either source.
REQ-026 While stall=1, fwd_a and fwd_b SHALL be 0.
REQ-027 Flush counter fc is 4 bits: flush = (br_resolve & br_taken) | (fc!=0).
REQ-028 On br_resolve & br_taken, fc SHALL load FLUSH_CYC-1; otherwise fc SHALL decrement while nonzero.
REQ-029 A taken branch arriving while fc!=0 SHALL reload fc, extending the flush.
REQ-030 flush SHALL override stall: when both conditions hold in the same cycle, stall=0.
REQ-031 perf_stall SHALL increment in each cycle with stall=1 and saturate at 16'hFFFF.
REQ-032 perf_flush SHALL increment once per br_resolve & br_taken event and saturate at 16'hFFFF.
REQ-033 A stall SHALL release on its own as the load advances, after LOAD_LAT+1-k cycles, with no external action.

Reset
REQ-034 While rst=1, all tracking entries SHALL have valid=0, and fc, perf_stall and perf_flush SHALL be 0.
REQ-035 While rst=1, fwd_a, fwd_b, stall and flush SHALL be forced to 0 regardless of inputs.
REQ-036 A reset asserted mid-flush or mid-stall SHALL clear all state immediately (asynchronously); the first post-reset cycle behaves as if the pipeline is empty.

Verification
REQ-037 Back-to-back dependency (defaults): write x5, then read rs1=x5 -> fwd_a=1; an instruction reading x5 two issues later -> fwd_a=2; after DEPTH+1 cycles -> fwd_a=0.
REQ-038 Load-use: load x7, then read rs2=x7 (LOAD_LAT=1) -> stall=1 for exactly 1 cycle, perf_stall=1, then fwd_b=2 with stall=0.
REQ-039 Register x0: write x0, then read rs1=x0 -> fwd_a=0, stall=0.
REQ-040 Youngest priority: entries 1 and 2 both write x3, decode reads rs1=x3 -> fwd_a=1.
REQ-041 Branch flush (FLUSH_CYC=2): taken branch at cycle t -> flush=1 at t and t+1, 0 at t+2, perf_flush=1; a second taken branch at t+1 -> flush=1 through t+2, perf_flush=2; a simultaneous load-use condition -> stall=0.
REQ-042 Reset: assert rst at t+1 of a flush and during a stall -> all outputs 0 immediately, counters 0, no forwarding from entries tracked before reset.
